// File: rtl/othello_task_dispatcher.sv
// Task dispatcher for the Othello solver pipeline: queues host tasks, fills the pipeline slots
// after start, then refills one slot per solved result. Macro DISPATCH_STATS_EN builds the stat counters.
module othello_task_dispatcher #(
  parameter int FIFO_DEPTH = 16,
  parameter int FILL_SLOTS = 9
) (
  input  logic               iCLOCK,
  input  logic               iRESET,
  input  logic               start,
  input  logic               task_valid,
  output logic               task_ready,
  input  logic [63:0]        task_player,
  input  logic [63:0]        task_opponent,
  input  logic [15:0]        task_id,
  output logic               pl_enable,
  output logic               pl_valid,
  output logic [63:0]        pl_player,
  output logic [63:0]        pl_opponent,
  output logic [15:0]        pl_taskid,
  input  logic               pl_solved,
  input  logic [15:0]        pl_res_taskid,
  input  logic signed [7:0]  pl_res,
  output logic               res_valid,
  output logic [15:0]        res_taskid,
  output logic signed [7:0]  res_value,
  output logic [3:0]         inflight,
  output logic               all_done,
  output logic [31:0]        stat_solved,
  output logic [31:0]        stat_idle_issues,
  output logic [1:0]         fsm_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILL_SLOTS + 1);
  localparam logic [15:0] IDLE_ID = 16'hffff;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2} state_t;

  typedef struct packed {
    logic [63:0] player;
    logic [63:0] opponent;
    logic [15:0] id;
  } task_t;

  task_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic [FW-1:0] fill_cnt;

  logic          push, pop, issue, empty, retire, real_issue, dec;
  logic [AW:0]   count_next;
  logic [3:0]    inflight_next;
  state_t        state_next;
  task_t         head;

  assign fsm_state = state;

  // Task handshake: a task transfers on every cycle where task_valid and task_ready are both high;
  // task_ready comes straight from a register and depends only on FIFO occupancy.
  always_comb begin
    empty      = (count == '0);
    head       = mem[rd_ptr];
    push       = task_valid && task_ready;
    issue      = 1'b0;
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          issue      = 1'b1;
          state_next = (FILL_SLOTS == 1) ? S_RUN : S_FILL;
        end
      end
      S_FILL: begin
        issue = 1'b1;
        if (fill_cnt == FW'(FILL_SLOTS - 1)) state_next = S_RUN;
      end
      S_RUN:   issue = pl_solved;
      default: state_next = S_IDLE;
    endcase
    pop        = issue && !empty;
    real_issue = pop && (head.id != IDLE_ID);
    // Results only count once a run has started; stale ones after reset are dropped.
    retire     = (state != S_IDLE) && pl_solved && (pl_res_taskid != IDLE_ID);
    dec        = retire && (inflight != 4'd0);
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    inflight_next = inflight;
    if (real_issue && !dec) begin
      if (inflight != 4'(FILL_SLOTS)) inflight_next = inflight + 4'd1;
    end else if (!real_issue && dec) begin
      inflight_next = inflight - 4'd1;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (push) mem[wr_ptr] <= '{player: task_player, opponent: task_opponent, id: task_id};
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fill_cnt    <= '0;
      inflight    <= 4'd0;
      task_ready  <= 1'b1;
      pl_enable   <= 1'b0;
      pl_valid    <= 1'b0;
      pl_player   <= '1;
      pl_opponent <= '0;
      pl_taskid   <= IDLE_ID;
      res_valid   <= 1'b0;
      res_taskid  <= IDLE_ID;
      res_value   <= '0;
      all_done    <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      inflight   <= inflight_next;
      task_ready <= (count_next != (AW+1)'(FIFO_DEPTH));
      all_done   <= (state_next == S_RUN) && (count_next == '0) && (inflight_next == 4'd0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // fill_cnt holds the number of fill issues already made, including the one on start.
      if (state == S_IDLE && start) fill_cnt <= FW'(1);
      else if (state == S_FILL)     fill_cnt <= fill_cnt + 1'b1;
      if (issue) begin
        pl_enable <= 1'b1;
        pl_valid  <= 1'b1;
        if (pop) begin
          pl_player   <= head.player;
          pl_opponent <= head.opponent;
          pl_taskid   <= head.id;
        end else begin
          pl_player   <= '1;
          pl_opponent <= '0;
          pl_taskid   <= IDLE_ID;
        end
      end
      res_valid <= retire;
      if (retire) begin
        res_taskid <= pl_res_taskid;
        res_value  <= pl_res;
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      stat_solved      <= '0;
      stat_idle_issues <= '0;
    end else begin
      if (retire)          stat_solved      <= stat_solved + 32'd1;
      if (issue && empty)  stat_idle_issues <= stat_idle_issues + 32'd1;
    end
  end
`else
  assign stat_solved      = '0;
  assign stat_idle_issues = '0;
`endif

endmodule
